// File: rtl/cipher_stream_ctrl.sv
// Message sequencer around the 8-bit LFSR cipher core: buffers a command's
// characters, feeds them to the core on back-to-back cycles, then drains results.
module cipher_stream_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int LW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_seed,
  input  logic [LW-1:0] cmd_len,
  output logic          cmd_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic          core_start,
  output logic [7:0]    core_seed,
  output logic [7:0]    core_ch_in,
  input  logic [7:0]    core_ch_out,
  input  logic          core_valid,
  output logic [LW-1:0] skip_count,
  output logic          done,
  output logic          busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LOAD, S_RUN, S_DRAIN} state_e;

  state_e        state_q;
  logic [7:0]    seed_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] wr_ptr_q;
  logic [LW-1:0] rd_ptr_q;
  logic [LW-1:0] idx_q;
  logic [LW-1:0] skip_q;
  logic          cmd_err_q;
  logic          done_q;
  logic [7:0]    buf_q [MAX_LEN];

  logic          len_ok;
  logic          in_fire;
  logic [LW-1:0] len_m1;

  assign len_ok  = (cmd_len != '0) && (cmd_len <= LW'(MAX_LEN));
  assign in_fire = (state_q == S_FILL) && in_valid;
  assign len_m1  = len_q - LW'(1);

  // NOTE: the buffer has no reset; every entry is written in FILL before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_q[wr_ptr_q[AW-1:0]] <= in_data;
    end else if ((state_q == S_RUN) && core_valid) begin
      buf_q[idx_q[AW-1:0]] <= core_ch_out;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      seed_q    <= 8'h00;
      len_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      idx_q     <= '0;
      skip_q    <= '0;
      cmd_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (len_ok) begin
              seed_q   <= cmd_seed;
              len_q    <= cmd_len;
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
              idx_q    <= '0;
              skip_q   <= '0;
              state_q  <= S_FILL;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (in_valid) begin
            wr_ptr_q <= wr_ptr_q + LW'(1);
            if (wr_ptr_q == len_m1) state_q <= S_LOAD;
          end
        end
        S_LOAD: state_q <= S_RUN;
        S_RUN: begin
          // The core's keystream steps every clock, so RUN never stalls.
          if (!core_valid) skip_q <= skip_q + LW'(1);
          if (idx_q == len_m1) state_q <= S_DRAIN;
          else                 idx_q   <= idx_q + LW'(1);
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (rd_ptr_q == len_m1) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              rd_ptr_q <= rd_ptr_q + LW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign in_ready   = (state_q == S_FILL);
  assign out_valid  = (state_q == S_DRAIN);
  assign busy       = (state_q != S_IDLE);
  assign core_start = (state_q == S_LOAD);
  assign core_seed  = seed_q;
  assign core_ch_in = (state_q == S_RUN) ? buf_q[idx_q[AW-1:0]] : 8'h00;
  assign out_data   = buf_q[rd_ptr_q[AW-1:0]];
  assign out_last   = (state_q == S_DRAIN) && (rd_ptr_q == len_m1);
  assign cmd_err    = cmd_err_q;
  assign done       = done_q;
  assign skip_count = skip_q;

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Directed bench for cipher_stream_ctrl with a behavioural LFSR core model
// (letters 0x40..0x7F are XORed with the low 6 keystream bits, others skipped).
module tb_cipher_stream_ctrl;

  localparam int MAX_LEN = 32;
  localparam int LW      = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_seed = 8'h00;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_last;
  logic          core_start;
  logic [7:0]    core_seed;
  logic [7:0]    core_ch_in;
  logic [7:0]    core_ch_out;
  logic          core_valid;
  logic [LW-1:0] skip_count;
  logic          done;
  logic          busy;

  cipher_stream_ctrl #(.MAX_LEN(MAX_LEN), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed),
    .cmd_len(cmd_len), .cmd_err(cmd_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_seed(core_seed), .core_ch_in(core_ch_in),
    .core_ch_out(core_ch_out), .core_valid(core_valid),
    .skip_count(skip_count), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] k);
    return {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
  endfunction

  // Core model: seed load on core_start, keystream advances every clock.
  logic [7:0] key = 8'h00;
  always @(posedge clk) key <= core_start ? core_seed : lfsr_next(key);
  assign core_ch_out = core_ch_in ^ {2'b00, key[5:0]};
  assign core_valid  = (core_ch_in[7:6] == 2'b01);

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int run_k = 99;
  int run_len = 0;
  int first_out_cyc = 0;
  int done_cnt = 0;
  int last_in_cyc = 0;
  bit seen_out = 1'b0;
  logic [7:0] msg   [MAX_LEN];
  logic [7:0] got   [MAX_LEN];
  logic [7:0] expv  [MAX_LEN];
  logic [7:0] ch_log[MAX_LEN];
  logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
      run_k     = 0;
    end else if (run_k < run_len) begin
      ch_log[run_k] = core_ch_in;
      run_k = run_k + 1;
    end
    if (out_valid && !seen_out) begin
      seen_out      = 1'b1;
      first_out_cyc = cyc;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed running, expected finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] seed, input int len, output int skips);
    logic [7:0] k;
    k = seed;
    skips = 0;
    for (int n = 0; n < len; n++) begin
      if (msg[n][7:6] == 2'b01) begin
        expv[n] = msg[n] ^ {2'b00, k[5:0]};
      end else begin
        expv[n] = msg[n];
        skips++;
      end
      k = lfsr_next(k);
    end
  endtask

  // Sends one legal command plus msg[0..len-1], collects results into got[].
  task automatic do_msg(input logic [7:0] seed, input int len, input bit gaps, input bit stalls);
    int guard;
    int i;
    int j;
    int bad;
    int start0;
    bit stalled;
    logic [7:0] prev;
    seen_out = 1'b0;
    run_len  = len;
    start0   = start_cnt;
    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_seed  = seed;
    cmd_len   = LW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("in_ready_after_cmd", 32'(in_ready), 1);
    i = 0;
    guard = 0;
    while (i < len && guard < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = msg[i];
      if (in_valid && in_ready) begin
        if (i == len - 1) last_in_cyc = cyc;
        i++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("fill_count", i, len);
    j = 0;
    guard = 0;
    stalled = 1'b0;
    prev = 8'h00;
    while (j < len && guard < 2000) begin
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(prev));
      end
      out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid) begin
        if (out_ready) begin
          got[j] = out_data;
          check($sformatf("out_last[%0d]", j), 32'(out_last), (j == len - 1) ? 1 : 0);
          j++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev    = out_data;
        end
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check("drain_count", j, len);
    check("done_pulse", 32'(done), 1);
    check("busy_after", 32'(busy), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("start_pulses", start_cnt - start0, 1);
    check("load_cycle", start_cyc - last_in_cyc, 1);
    check("first_out_cycle", first_out_cyc - last_in_cyc, len + 2);
    check("core_seed_held", 32'(core_seed), 32'(seed));
    bad = 0;
    for (int n = 0; n < len; n++) if (ch_log[n] !== msg[n]) bad++;
    check("run_ch_in_seq_errors", bad, 0);
  endtask

  initial begin
    int sk;
    bit saw;
    int done0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_cmd_err", 32'(cmd_err), 0);
    check("rst_done", 32'(done), 0);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_core_ch_in", 32'(core_ch_in), 0);
    check("rst_core_seed", 32'(core_seed), 0);
    check("rst_skip", 32'(skip_count), 0);
    rst = 1'b0;

    // "Hello", seed A5, no gaps
    for (int n = 0; n < 5; n++) msg[n] = hello[n];
    model(8'hA5, 5, sk);
    do_msg(8'hA5, 5, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) check($sformatf("hello_ct[%0d]", n), 32'(got[n]), 32'(expv[n]));
    check("hello_skip", 32'(skip_count), sk);

    // Round trip of the ciphertext
    for (int n = 0; n < 5; n++) msg[n] = got[n];
    do_msg(8'hA5, 5, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) check($sformatf("roundtrip[%0d]", n), 32'(got[n]), 32'(hello[n]));
    check("roundtrip_skip", 32'(skip_count), 0);

    // "HI!" with a pass-through character
    msg[0] = 8'h48; msg[1] = 8'h49; msg[2] = 8'h21;
    model(8'h3C, 3, sk);
    do_msg(8'h3C, 3, 1'b0, 1'b0);
    check("hi_ct[0]", 32'(got[0]), 32'(expv[0]));
    check("hi_ct[1]", 32'(got[1]), 32'(expv[1]));
    check("hi_bang", 32'(got[2]), 32'h21);
    check("hi_skip", 32'(skip_count), 1);

    // Illegal lengths 0 and 33
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_seed  = 8'h5A;
      cmd_len   = (t == 0) ? LW'(0) : LW'(33);
      in_valid  = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check($sformatf("illegal%0d_err", t), 32'(cmd_err), 1);
      check($sformatf("illegal%0d_idle", t), 32'(cmd_ready), 1);
      @(negedge clk);
      check($sformatf("illegal%0d_err_end", t), 32'(cmd_err), 0);
      saw = 1'b0;
      repeat (5) begin
        if (in_ready || busy) saw = 1'b1;
        @(negedge clk);
      end
      check($sformatf("illegal%0d_no_fill", t), 32'(saw), 0);
      in_valid = 1'b0;
    end

    // len 32 with input gaps and output stalls
    for (int n = 0; n < 32; n++)
      msg[n] = (n % 7 == 3) ? 8'($urandom_range(48, 57)) : 8'($urandom_range(65, 90));
    model(8'h5E, 32, sk);
    do_msg(8'h5E, 32, 1'b1, 1'b1);
    for (int n = 0; n < 32; n++) check($sformatf("long_ct[%0d]", n), 32'(got[n]), 32'(expv[n]));
    check("long_skip", 32'(skip_count), sk);
    repeat (3) @(negedge clk);
    check("skip_held_idle", 32'(skip_count), sk);

    // Reset during RUN at idx 2
    for (int n = 0; n < 5; n++) msg[n] = hello[n];
    run_len = 5;
    done0 = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_seed  = 8'h11;
    cmd_len   = LW'(5);
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      in_data = msg[n];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_run_idx2_ch", 32'(core_ch_in), 32'(msg[2]));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", 32'(cmd_ready), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ch_in", 32'(core_ch_in), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      if (out_valid) saw = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("midrst_no_output", 32'(saw), 0);
    check("midrst_no_done", done_cnt - done0, 0);

    model(8'h77, 5, sk);
    do_msg(8'h77, 5, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) check($sformatf("post_rst_ct[%0d]", n), 32'(got[n]), 32'(expv[n]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
